hilo_mdu_ctrl: RTL
==================

// Module: hilo_mdu_ctrl
// PURPOSE
//  Iterative multiply/divide sequencer feeding the HI/LO register pair.
//  - Accepts MULT/MULTU/DIV/DIVU from the execute stage.
//  - Runs a 32-step shift-add / restoring-divide loop and holds the pipeline via stall_o while busy.
//  - Emits one hilo_we_o pulse with the final HI/LO values.
//  - Replaces the fixed-constant ALU path into hilo_reg.
// PARAMETERS
//  WIDTH  32  operand / HI / LO width
//  CNT_W  6   iteration counter width; must hold WIDTH
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      asynchronous, active-low reset
//  start_i    in   1      E-stage instruction is mul/div; held high while the instruction sits in E
//  op_i       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled on accept
//  a_i        in   WIDTH  rs operand, forwarded value; sampled on accept
//  b_i        in   WIDTH  rt operand, forwarded value; sampled on accept
//  cancel_i   in   1      flush of the E-stage instruction; aborts the operation
//  stall_o    out  1      hold F/D/E
//  busy_o     out  1      FSM not IDLE
//  done_o     out  1      result cycle
//  hilo_we_o  out  1      write strobe to hilo_reg
//  hi_o       out  WIDTH  HI result; MUL high word / DIV remainder
//  lo_o       out  WIDTH  LO result; MUL low word / DIV quotient
// BEHAVIOUR
//  Reset (rst=0, async):
//  - State IDLE, counter=0.
//  - All internal regs, hi_o and lo_o = 0.
//  - stall_o, busy_o, done_o and hilo_we_o = 0.
//  States:
//  - IDLE: accept when start_i & ~cancel_i.
//    - Latch op and |a|, |b|; abs applies only for signed ops, unsigned ops use raw values.
//    - Latch result-sign flags; clear accumulator; go to BUSY.
//    - stall_o = start_i & ~cancel_i, combinational in the accept cycle.
//  - BUSY: stall_o=1.
//    - One iteration per cycle, counter 0..WIDTH-1.
//    - At counter==WIDTH-1, go to FIX.
//  - FIX: stall_o=1.
//    - Apply sign correction: product negated if sa^sb; quotient negated if sa^sb; remainder negated if sa.
//    - Register hi_o/lo_o; go to DONE.
//  - DONE: done_o=1, hilo_we_o=1, stall_o=0 so the instruction leaves E.
//    - start_i is ignored in this cycle (same instruction); always go to IDLE.
//  Latency:
//  - Accept at cycle 0; DONE at cycle WIDTH+2 (34).
//  - Back-to-back mul/div: the next start is accepted in the cycle after DONE.
//  Arithmetic:
//  - MUL uses a 2*WIDTH product register, shift-add, LSB-first.
//  - DIV uses restoring division with a WIDTH+1 bit partial remainder.
//  - Negation is two's complement modulo 2^WIDTH.
//  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//  - Divide by zero (b=0): loop still runs full length; result forced hi=a_i as latched (signed or raw), lo=all-ones.
//  Cancel:
//  - cancel_i in BUSY or FIX: go to IDLE next cycle, no hilo_we_o, hi_o/lo_o unchanged.
//  - cancel_i in DONE: hilo_we_o suppressed.
//  - cancel_i with start_i in IDLE: no accept.
//  hi_o/lo_o hold their last written value outside DONE.
//  Reset mid-operation: immediate return to IDLE and zeroed outputs; no write issued.
// TESTING
//  1. MULT a=0xFFFFFFFD b=5 -> DONE at cycle 34: hi=0xFFFFFFFF lo=0xFFFFFFF1 we=1 for 1 cycle; stall high cycles 0..33.
//  2. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//  3. DIVU 100/7 -> lo=14 hi=2.
//     DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//     DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  4. DIV a=123 b=0 -> hi=123 lo=0xFFFFFFFF, normal latency.
//  5. Start DIVU, assert cancel_i at cycle 10 -> IDLE at 11, stall_o=0, no we; new MULTU 3*4 at 12 -> lo=12 at 46.
//  6. Pulse rst low at cycle 20 of a MULT -> outputs 0, IDLE; start_i held high after release -> fresh op accepted, correct result.

Source files
------------

// File: rtl/hilo_mdu_ctrl.sv
// Iterative multiply/divide sequencer for the HI/LO register pair.
// Runs a 32-step shift-add multiply or restoring divide on operand magnitudes.
// It then applies sign correction and issues a single write strobe toward hilo_reg.
module hilo_mdu_ctrl #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             hilo_we_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              div_q, div_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [Width-1:0]  a_q, a_d;
  logic [Width-1:0]  b_q, b_d;
  logic [Width-1:0]  acc_hi_q, acc_hi_d;
  logic [Width-1:0]  acc_lo_q, acc_lo_d;
  logic [Width-1:0]  hi_q, hi_d;
  logic [Width-1:0]  lo_q, lo_d;

  logic              a_neg, b_neg;
  logic [Width-1:0]  a_abs, b_abs;
  logic [Width:0]    mul_sum, rem_sh, diff;
  logic [Width-1:0]  step_hi, step_lo;
  logic [2*Width-1:0] prod, prod_fix;
  logic [Width-1:0]  fix_hi, fix_lo;

  // Operand magnitudes; unsigned ops (op_i[0]=1) keep raw values.
  always_comb begin
    a_neg = ~op_i[0] & a_i[Width-1];
    b_neg = ~op_i[0] & b_i[Width-1];
    a_abs = a_neg ? -a_i : a_i;
    b_abs = b_neg ? -b_i : b_i;
  end

  // One loop iteration: LSB-first shift-add for MUL, restoring step for DIV.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {acc_hi_q, acc_lo_q[Width-1]};
    diff    = rem_sh - {1'b0, b_q};
    if (!div_q) begin
      step_hi = mul_sum[Width:1];
      step_lo = {mul_sum[0], acc_lo_q[Width-1:1]};
    end else if (!diff[Width]) begin
      step_hi = diff[Width-1:0];
      step_lo = {acc_lo_q[Width-2:0], 1'b1};
    end else begin
      step_hi = rem_sh[Width-1:0];
      step_lo = {acc_lo_q[Width-2:0], 1'b0};
    end
  end

  // Sign correction of the magnitude result; divide by zero forces hi=a, lo=all-ones.
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    if (!div_q) begin
      fix_hi = prod_fix[2*Width-1:Width];
      fix_lo = prod_fix[Width-1:0];
    end else if (b_q == '0) begin
      fix_hi = sa_q ? -a_q : a_q;
      fix_lo = '1;
    end else begin
      fix_hi = sa_q ? -acc_hi_q : acc_hi_q;
      fix_lo = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
    end
  end

  // Sequencer next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    hilo_we_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && !cancel_i) begin
          stall_o  = 1'b1;
          div_d    = op_i[1];
          sa_d     = a_neg;
          sb_d     = b_neg;
          a_d      = a_abs;
          b_d      = b_abs;
          acc_hi_d = '0;
          acc_lo_d = a_abs;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        stall_o = 1'b1;
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StFix;
        end
      end
      StFix: begin
        stall_o = 1'b1;
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = StDone;
        end
      end
      StDone: begin
        // start_i here still belongs to the finishing instruction.
        done_o    = 1'b1;
        hilo_we_o = ~cancel_i;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared by asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
